// File: rtl/seq_booth_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The requester uses the master modport, the divider uses the slave modport.
interface seq_booth_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_booth_divider.sv
// Iterative restoring divider on operand magnitudes: one quotient bit per cycle,
// then a sign-fix cycle. Fixed latency of WIDTH+2 cycles from start to done.
module seq_booth_divider #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    seq_booth_divider_if.slave  dif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dvz_q, dvz_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        state_d       = state_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        sgn_d         = sgn_q;
        dvs_mag_d     = dvs_mag_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        cnt_d         = cnt_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dvz_d         = dvz_q;
        ovf_d         = ovf_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        shifted       = '0;
        trial         = '0;
        q_fix         = '0;
        r_fix         = '0;

        case (state_q)
            IDLE: begin
                if (dif.start) begin
                    dvd_d   = dif.dividend;
                    dvs_d   = dif.divisor;
                    sgn_d   = dif.is_signed;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                // Negating the most negative value wraps to itself, which is its magnitude.
                quo_d     = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                dvs_mag_d = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                q_neg_d   = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                r_neg_d   = sgn_q & dvd_q[WIDTH-1];
                dvz_d     = (dvs_q == '0);
                ovf_d     = sgn_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == '1);
                rem_d     = '0;
                cnt_d     = CW'(WIDTH);
                state_d   = ITER;
            end
            ITER: begin
                shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
                trial   = shifted - {1'b0, dvs_mag_q};
                if (!trial[WIDTH]) begin
                    rem_d = trial;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                q_fix = q_neg_q ? -quo_q : quo_q;
                r_fix = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                if (dvz_q) begin
                    quotient_d    = '1;
                    remainder_d   = dvd_q;
                    div_by_zero_d = 1'b1;
                end else if (ovf_q) begin
                    quotient_d    = dvd_q;
                    remainder_d   = '0;
                    div_by_zero_d = 1'b0;
                end else begin
                    quotient_d    = q_fix;
                    remainder_d   = r_fix;
                    div_by_zero_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dvd_q         <= '0;
            dvs_q         <= '0;
            sgn_q         <= 1'b0;
            dvs_mag_q     <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dvz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            sgn_q         <= sgn_d;
            dvs_mag_q     <= dvs_mag_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            cnt_q         <= cnt_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dvz_q         <= dvz_d;
            ovf_q         <= ovf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign dif.busy        = busy_q;
    assign dif.done        = done_q;
    assign dif.quotient    = quotient_q;
    assign dif.remainder   = remainder_q;
    assign dif.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_seq_booth_divider.sv
// Scoreboard bench for seq_booth_divider: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_seq_booth_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_booth_divider_if #(.WIDTH(W)) dif();
    seq_booth_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .dif(dif));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           when;
    } exp_t;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs [9] = '{
        '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0},
        '{1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0},
        '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0},
        '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0},
        '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0},
        '{1'b1, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1'b1},
        '{1'b0, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1'b1},
        '{1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1},
        '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0}
    };

    exp_t sb [$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && dif.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", dif.quotient, e.q);
                chk("remainder", dif.remainder, e.r);
                chk("div_by_zero", W'(dif.div_by_zero), W'(e.dz));
                chk("latency", W'(cyc), W'(e.when));
                chk("busy_in_done", W'(dif.busy), W'(0));
                $display("txn q=%h r=%h dz=%0d cycle=%0d", dif.quotient, dif.remainder,
                         dif.div_by_zero, cyc);
            end
        end
    end

    // Called just after a negedge; start is held across exactly one posedge.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz);
        exp_t x;
        dif.start     = 1'b1;
        dif.is_signed = sgn;
        dif.dividend  = a;
        dif.divisor   = b;
        if (push) begin
            x.q    = eq;
            x.r    = er;
            x.dz   = edz;
            x.when = cyc + 1 + W + 2;
            sb.push_back(x);
        end
        @(negedge clk);
        dif.start     = 1'b0;
        dif.is_signed = ~sgn;
        dif.dividend  = $urandom;
        dif.divisor   = $urandom;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (dif.done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (dif.done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_done actual=timeout required=done_within_%0d", bound);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, W'(dif.busy), W'(0));
        chk({tag, "_done"}, W'(dif.done), W'(0));
        chk({tag, "_quotient"}, dif.quotient, W'(0));
        chk({tag, "_remainder"}, dif.remainder, W'(0));
        chk({tag, "_dz"}, W'(dif.div_by_zero), W'(0));
    endtask

    initial begin
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        // Unsigned 100/7 with busy profile across the whole operation.
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        for (int i = 0; i < W + 2; i++) begin
            chk("busy_high", W'(dif.busy), W'(1));
            chk("done_low", W'(dif.done), W'(0));
            @(negedge clk);
        end
        chk("done_high", W'(dif.done), W'(1));

        // Back-to-back directed vectors, each issued in the previous done cycle.
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].s, vecs[v].a, vecs[v].b, 1'b1, vecs[v].q, vecs[v].r, vecs[v].dz);
            wait_done(W + 5);
        end

        // Start while busy is ignored; a start in the done cycle is accepted.
        issue(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        issue(1'b0, 32'd9, 32'd2, 1'b0, '0, '0, 1'b0);
        wait_done(W + 5);
        issue(1'b0, 32'd9, 32'd2, 1'b1, 32'd4, 32'd1, 1'b0);
        wait_done(W + 5);

        // Reset mid-operation aborts with no done pulse.
        issue(1'b0, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("abort");
        repeat (W + 8) @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0);
        wait_done(W + 5);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", W'(sb.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_booth_divider.md
Name: seq_booth_divider

Overview:
- Iterative signed/unsigned integer divider; the inverse operation of the team's sequential radix-4 Booth multiplier.
- Sits beside the multiplier in the arithmetic unit and uses the same load-then-iterate style.
- Computes quotient and remainder of two WIDTH-bit operands using restoring division on magnitudes: one quotient bit per cycle, then a sign-fix cycle.
- Start/busy/done handshake; RISC-V-compatible divide-by-zero and overflow results.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >= 4).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  quotient, held until next done.
- remainder  output  WIDTH  remainder, held until next done.
- div_by_zero  output  1  divisor was zero; updated with done, held.

Behaviour:
- Reset: clk and rst are the decided clock and reset; rst is synchronous, active-high. All outputs and internal registers reset to 0; state = IDLE.
- rst dominates start. rst mid-operation aborts, returns to IDLE, no done pulse.
- States: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE:
  - start=1 latches dividend, divisor and is_signed; next state PREP.
  - start=0 stays in IDLE.
- PREP (1 cycle):
  - Computes operand magnitudes (negate if is_signed and MSB=1). Magnitude of the most negative value is its WIDTH-bit unsigned pattern.
  - Records quotient sign = is_signed & (dividend MSB ^ divisor MSB).
  - Records remainder sign = is_signed & dividend MSB.
  - Flags zero divisor.
  - Clears the (WIDTH+1)-bit partial remainder; loads the dividend magnitude into the quotient shift register.
  - Loads iteration counter = WIDTH.
- ITER (exactly WIDTH cycles, count-down counter, exit at 1 -> FIX). Each cycle:
  - Shift {partial remainder, quotient} left by 1.
  - trial = partial remainder - divisor magnitude, computed in WIDTH+1 bits.
  - If trial >= 0: partial remainder <= trial and quotient LSB <= 1. Otherwise restore and quotient LSB <= 0.
- FIX (1 cycle):
  - Negate the quotient and/or remainder magnitude per the recorded signs.
  - Apply the special cases below.
  - Register quotient, remainder and div_by_zero; assert done next cycle; next state IDLE.
- Special cases (applied in FIX; latency unchanged):
  - Divisor = 0: quotient = all ones, remainder = original dividend, div_by_zero = 1.
  - Signed overflow (dividend = 1 followed by zeros, divisor = all ones): quotient = dividend, remainder = 0, div_by_zero = 0.
  - Unsigned mode never overflows.
- Latency: if start is sampled at edge k, done is high during the cycle after edge k+WIDTH+2, i.e. WIDTH+2 cycles after start (34 for WIDTH=32). The latency is fixed and data-independent.
- busy: high from the cycle after start is sampled through the FIX cycle. It is low in the done cycle and in IDLE.
- done: registered, high for exactly one cycle.
- Handshake boundaries:
  - start while busy is ignored; no queuing, latched operands unaffected.
  - start in the done cycle is accepted, since state is already IDLE (back-to-back throughput = WIDTH+2 cycles).
  - Input changes after the start cycle have no effect.
- Results satisfy: dividend = quotient*divisor + remainder, |remainder| < |divisor|, and remainder sign = dividend sign (truncating division).

Test Plan:
- Unsigned 100 / 7, start pulse at cycle 0 -> done high at cycle 34 only; quotient=14, remainder=2, div_by_zero=0; busy high cycles 1-33.
- Signed -100 / 7 (0xFFFFFF9C, 7) -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Signed 100 / -7 -> quotient=0xFFFFFFF2, remainder=2.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Same operands unsigned -> quotient=0, remainder=0x80000000.
- 1234 / 0 (signed and unsigned) -> quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1; done still at cycle 34.
- Start 50/5 at cycle 0, second start 9/2 at cycle 10 (ignored) -> done at 34 with q=10, r=0. New start 9/2 during the done cycle -> done 34 cycles later, q=4, r=1.
- Start 1000/3, assert rst at cycle 10 for one cycle -> busy=0 and all outputs 0 from cycle 11, no done pulse. Next start 1000/3 -> q=333, r=1 at normal latency.
